acc_core_mc: RTL and testbench

Parametrised multicycle accumulator processor core, the next generation of the 12-bit accumulator processor. It generalises data width, address width and general-register count, and replaces fixed single-cycle data-memory enables with a req/ack handshake that tolerates wait states. It also adds conditional branches on a zero flag and illegal-opcode trapping. It sits between the instruction ROM and the data-memory controller in the FPGA top level.

---
 rtl/acc_core_pkg.sv | 47 ++++
 rtl/acc_core_alu.sv | 33 +++
 rtl/acc_core_mc.sv | 190 +++++++++++++++++++
 tb/tb_acc_core_mc.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_core_pkg.sv
// Shared definitions for the multicycle accumulator core.
// Contents: opcode width, opcode and FSM state enums, and small decode
// helpers used by the core and its ALU.
package acc_core_pkg;

   localparam int OPC_W = 5;

   typedef enum logic [OPC_W-1:0] {
      OP_NOP = 5'd0,
      OP_LDI = 5'd1,
      OP_LDM = 5'd2,
      OP_STM = 5'd3,
      OP_MVR = 5'd4,
      OP_MRA = 5'd5,
      OP_ADD = 5'd6,
      OP_SUB = 5'd7,
      OP_MUL = 5'd8,
      OP_INC = 5'd9,
      OP_CLR = 5'd10,
      OP_JMP = 5'd11,
      OP_JZ  = 5'd12,
      OP_JNZ = 5'd13,
      OP_END = 5'd31
   } opcode_e;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_HALT
   } state_e;

   function automatic logic is_legal(input logic [OPC_W-1:0] op);
      return (op <= 5'd13) || (op == 5'd31);
   endfunction

   // Instructions executed in EXEC that write AC (and therefore z).
   // LDM writes AC too, but from the MEM state.
   function automatic logic writes_ac(input opcode_e op);
      case (op)
         OP_LDI, OP_MRA, OP_ADD, OP_SUB, OP_MUL, OP_INC, OP_CLR: return 1'b1;
         default:                                               return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/acc_core_alu.sv
// Combinational ALU for the accumulator core.
// Ports:
//   op     - opcode selecting the operation
//   a      - accumulator operand
//   b      - second operand (register value, or immediate for LDI)
//   result - new accumulator value, modulo 2^DATA_W
//   zero   - result == 0
module acc_core_alu
   import acc_core_pkg::*;
#(
   parameter int DATA_W = 12
) (
   input  opcode_e           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              zero
);

   always_comb begin
      result = b;
      case (op)
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_MUL:  result = a * b;
         OP_INC:  result = a + DATA_W'(1);
         OP_CLR:  result = '0;
         default: result = b;
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/acc_core_mc.sv
// Multicycle accumulator processor core.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   im_addr, im_data  - instruction ROM address (= PC) / word, one-cycle latency
//   dm_req, dm_we, dm_addr, dm_wdata, dm_ack, dm_rdata
//                     - registered data-memory request held until dm_ack
//   pc_out, ac_out    - debug views of PC and AC
//   end_process       - halted by END
//   illegal           - halted by an undefined opcode
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_FETCH  | present PC on im_addr
// ST_DECODE | latch IR, PC+1, dispatch to EXEC / MEM / HALT
// ST_EXEC   | ALU op, register move or branch
// ST_MEM    | dm_req held; wait for dm_ack, LDM writes AC and z
// ST_HALT   | absorbing until reset
module acc_core_mc
   import acc_core_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 12,
   parameter int NREG   = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   output logic [ADDR_W-1:0]       im_addr,
   input  logic [ADDR_W+OPC_W-1:0] im_data,
   output logic                    dm_req,
   output logic                    dm_we,
   output logic [ADDR_W-1:0]       dm_addr,
   output logic [DATA_W-1:0]       dm_wdata,
   input  logic                    dm_ack,
   input  logic [DATA_W-1:0]       dm_rdata,
   output logic [ADDR_W-1:0]       pc_out,
   output logic [DATA_W-1:0]       ac_out,
   output logic                    end_process,
   output logic                    illegal
);

   localparam int IR_W  = ADDR_W + OPC_W;
   localparam int IDX_W = $clog2(NREG);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   ac_q, ac_d;
   logic                z_q, z_d;
   logic [IR_W-1:0]     ir_q, ir_d;
   logic [DATA_W-1:0]   regs_q [NREG];
   logic [DATA_W-1:0]   regs_d [NREG];
   logic                dm_req_q, dm_req_d;
   logic                dm_we_q, dm_we_d;
   logic [ADDR_W-1:0]   dm_addr_q, dm_addr_d;
   logic [DATA_W-1:0]   dm_wdata_q, dm_wdata_d;
   logic                end_q, end_d;
   logic                ill_q, ill_d;

   opcode_e             ir_op, dec_op;
   logic [ADDR_W-1:0]   ir_opd, dec_opd;
   logic [IDX_W-1:0]    ir_idx;
   logic [DATA_W-1:0]   alu_b, alu_res;
   logic                alu_zero;

   // DECODE dispatches on the ROM word directly; IR is only valid from EXEC on.
   assign dec_op  = opcode_e'(im_data[IR_W-1 -: OPC_W]);
   assign dec_opd = im_data[ADDR_W-1:0];
   assign ir_op   = opcode_e'(ir_q[IR_W-1 -: OPC_W]);
   assign ir_opd  = ir_q[ADDR_W-1:0];
   assign ir_idx  = ir_opd[IDX_W-1:0];

   assign alu_b = (ir_op == OP_LDI) ? DATA_W'(ir_opd) : regs_q[ir_idx];

   acc_core_alu #(.DATA_W(DATA_W)) u_alu (
      .op     (ir_op),
      .a      (ac_q),
      .b      (alu_b),
      .result (alu_res),
      .zero   (alu_zero)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ac_d       = ac_q;
      z_d        = z_q;
      ir_d       = ir_q;
      regs_d     = regs_q;
      dm_req_d   = dm_req_q;
      dm_we_d    = dm_we_q;
      dm_addr_d  = dm_addr_q;
      dm_wdata_d = dm_wdata_q;
      end_d      = end_q;
      ill_d      = ill_q;

      case (state_q)
         ST_FETCH: state_d = ST_DECODE;
         ST_DECODE: begin
            ir_d = im_data;
            pc_d = pc_q + ADDR_W'(1);
            if (dec_op == OP_LDM || dec_op == OP_STM) begin
               // Request fields are loaded here so they are registered and
               // stable from the first MEM cycle.
               state_d    = ST_MEM;
               dm_req_d   = 1'b1;
               dm_we_d    = (dec_op == OP_STM);
               dm_addr_d  = dec_opd;
               dm_wdata_d = ac_q;
            end else if (dec_op == OP_END) begin
               state_d = ST_HALT;
               end_d   = 1'b1;
            end else if (!is_legal(im_data[IR_W-1 -: OPC_W])) begin
               state_d = ST_HALT;
               ill_d   = 1'b1;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = ST_FETCH;
            if (writes_ac(ir_op)) begin
               ac_d = alu_res;
               z_d  = alu_zero;
            end
            case (ir_op)
               OP_MVR:  regs_d[ir_idx] = ac_q;
               OP_JMP:  pc_d = ir_opd;
               OP_JZ:   if (z_q)  pc_d = ir_opd;
               OP_JNZ:  if (!z_q) pc_d = ir_opd;
               default: ;
            endcase
         end
         ST_MEM: begin
            if (dm_ack) begin
               state_d    = ST_FETCH;
               dm_req_d   = 1'b0;
               dm_we_d    = 1'b0;
               dm_addr_d  = '0;
               dm_wdata_d = '0;
               if (!dm_we_q) begin
                  ac_d = dm_rdata;
                  z_d  = (dm_rdata == '0);
               end
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_FETCH;
         pc_q       <= '0;
         ac_q       <= '0;
         z_q        <= 1'b0;
         ir_q       <= '0;
         dm_req_q   <= 1'b0;
         dm_we_q    <= 1'b0;
         dm_addr_q  <= '0;
         dm_wdata_q <= '0;
         end_q      <= 1'b0;
         ill_q      <= 1'b0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ac_q       <= ac_d;
         z_q        <= z_d;
         ir_q       <= ir_d;
         dm_req_q   <= dm_req_d;
         dm_we_q    <= dm_we_d;
         dm_addr_q  <= dm_addr_d;
         dm_wdata_q <= dm_wdata_d;
         end_q      <= end_d;
         ill_q      <= ill_d;
         regs_q     <= regs_d;
      end
   end

   assign im_addr     = pc_q;
   assign pc_out      = pc_q;
   assign ac_out      = ac_q;
   assign dm_req      = dm_req_q;
   assign dm_we       = dm_we_q;
   assign dm_addr     = dm_addr_q;
   assign dm_wdata    = dm_wdata_q;
   assign end_process = end_q;
   assign illegal     = ill_q;

endmodule

// File: tb/tb_acc_core_mc.sv
module tb_acc_core_mc;

   localparam int DW = 12;
   localparam int AW = 12;
   localparam int NR = 4;
   localparam int IW = AW + 5;

   localparam int I_NOP = 0, I_LDI = 1, I_LDM = 2, I_STM = 3, I_MVR = 4, I_MRA = 5;
   localparam int I_ADD = 6, I_SUB = 7, I_MUL = 8, I_INC = 9, I_CLR = 10;
   localparam int I_JMP = 11, I_JZ = 12, I_JNZ = 13, I_END = 31;
   localparam int PLEN = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] im_addr;
   logic [IW-1:0] im_data;
   logic          dm_req, dm_we, dm_ack;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata, dm_rdata;
   logic [AW-1:0] pc_out;
   logic [DW-1:0] ac_out;
   logic          end_process, illegal;

   logic [IW-1:0] rom  [0:4095];
   logic [DW-1:0] dmem [0:4095];
   int            mdm  [8];

   int   checks = 0;
   int   errors = 0;
   int   ack_lat = 1;
   logic ack_force = 1'b0;
   int   mem_cyc = 0;

   int            req_cnt;
   logic          req_unstable;
   logic          first_we;
   logic [AW-1:0] first_addr;
   logic [DW-1:0] first_wdata;

   acc_core_mc #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .im_addr     (im_addr),
      .im_data     (im_data),
      .dm_req      (dm_req),
      .dm_we       (dm_we),
      .dm_addr     (dm_addr),
      .dm_wdata    (dm_wdata),
      .dm_ack      (dm_ack),
      .dm_rdata    (dm_rdata),
      .pc_out      (pc_out),
      .ac_out      (ac_out),
      .end_process (end_process),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   always @(posedge clk) im_data <= rom[im_addr];
   assign dm_rdata = dmem[dm_addr];

   // Memory responder: ack after ack_lat MEM cycles; stores land in the ack cycle.
   always @(negedge clk) begin
      if (dm_req) begin
         if (mem_cyc == ack_lat - 1) begin
            dm_ack = 1'b1;
            if (dm_we) dmem[dm_addr] = dm_wdata;
         end else begin
            dm_ack = 1'b0;
         end
         mem_cyc++;
      end else begin
         mem_cyc = 0;
         dm_ack  = ack_force;
      end
   end

   typedef struct {
      int          op;
      logic [11:0] a;
      logic [11:0] r;
      logic [11:0] exp_ac;
      logic        exp_z;
   } vec_t;
   vec_t vecs [11];

   function automatic logic [IW-1:0] ins(input int op, input int opd);
      return {op[4:0], opd[11:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 4096; i++) rom[i] = ins(I_END, 0);
   endtask

   task automatic do_reset();
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
   endtask

   // Called at a negedge; counts rising edges until the core halts.
   task automatic wait_halt(input int max_cyc, output int cyc);
      cyc = 0;
      req_cnt = 0;
      req_unstable = 1'b0;
      while (!(end_process || illegal) && cyc < max_cyc) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (dm_req) begin
            if (req_cnt == 0) begin
               first_we    = dm_we;
               first_addr  = dm_addr;
               first_wdata = dm_wdata;
            end else if ({dm_we, dm_addr, dm_wdata} != {first_we, first_addr, first_wdata}) begin
               req_unstable = 1'b1;
            end
            req_cnt++;
         end
      end
      if (!(end_process || illegal)) chk("halt_timeout", 32'(end_process | illegal), 1);
   endtask

   task automatic run_prog(input int max_cyc, output int cyc);
      do_reset();
      wait_halt(max_cyc, cyc);
   endtask

   // Instruction-level reference: executes the ROM program with the ISA rules
   // and charges 3 cycles per plain op, 2+lat per memory op, 2 for the halt.
   task automatic model_run(input int lat, output int m_ac, output int m_pc,
                            output int m_cyc, output int m_end, output int m_ill);
      int pc, ac, z, op, opd;
      int r [4];
      logic [IW-1:0] w;
      pc = 0; ac = 0; z = 0;
      for (int i = 0; i < 4; i++) r[i] = 0;
      m_cyc = 0; m_end = 0; m_ill = 0;
      for (int step = 0; step < 500 && m_end == 0 && m_ill == 0; step++) begin
         w   = rom[pc];
         op  = int'(w[16:12]);
         opd = int'(w[11:0]);
         pc  = (pc + 1) % 4096;
         m_cyc += 3;
         case (op)
            I_NOP: ;
            I_LDI: ac = opd;
            I_LDM: begin ac = mdm[opd]; m_cyc += lat - 1; end
            I_STM: begin mdm[opd] = ac; m_cyc += lat - 1; end
            I_MVR: r[opd % 4] = ac;
            I_MRA: ac = r[opd % 4];
            I_ADD: ac = (ac + r[opd % 4]) % 4096;
            I_SUB: ac = (ac - r[opd % 4] + 4096) % 4096;
            I_MUL: ac = (ac * r[opd % 4]) % 4096;
            I_INC: ac = (ac + 1) % 4096;
            I_CLR: ac = 0;
            I_JMP: pc = opd;
            I_JZ:  if (z != 0) pc = opd;
            I_JNZ: if (z == 0) pc = opd;
            I_END: begin m_end = 1; m_cyc -= 1; end
            default: begin m_ill = 1; m_cyc -= 1; end
         endcase
         if (op inside {I_LDI, I_LDM, I_MRA, I_ADD, I_SUB, I_MUL, I_INC, I_CLR})
            z = (ac == 0) ? 1 : 0;
      end
      m_ac = ac;
      m_pc = pc;
   endtask

   initial begin
      int cyc, k;
      int m_ac, m_pc, m_cyc, m_end, m_ill;
      int ops [14] = '{I_NOP, I_LDI, I_LDM, I_STM, I_MVR, I_MRA, I_ADD,
                       I_SUB, I_MUL, I_INC, I_CLR, I_JMP, I_JZ, I_JNZ};

      vecs[0]  = '{I_ADD, 12'hFFF, 12'h001, 12'h000, 1'b1};
      vecs[1]  = '{I_ADD, 12'h123, 12'h456, 12'h579, 1'b0};
      vecs[2]  = '{I_SUB, 12'h003, 12'h005, 12'hFFE, 1'b0};
      vecs[3]  = '{I_SUB, 12'h7AB, 12'h7AB, 12'h000, 1'b1};
      vecs[4]  = '{I_MUL, 12'h040, 12'h040, 12'h000, 1'b1};
      vecs[5]  = '{I_MUL, 12'h003, 12'h005, 12'h00F, 1'b0};
      vecs[6]  = '{I_MUL, 12'h0FF, 12'h011, 12'h0EF, 1'b0};
      vecs[7]  = '{I_INC, 12'hFFF, 12'h123, 12'h000, 1'b1};
      vecs[8]  = '{I_CLR, 12'h005, 12'h009, 12'h000, 1'b1};
      vecs[9]  = '{I_MRA, 12'h000, 12'hA5A, 12'hA5A, 1'b0};
      vecs[10] = '{I_NOP, 12'h000, 12'h111, 12'h000, 1'b1};

      clear_rom();
      for (int i = 0; i < 4096; i++) dmem[i] = '0;
      dm_ack = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_im_addr", 32'(im_addr), 0);
      chk("rst_pc", 32'(pc_out), 0);
      chk("rst_ac", 32'(ac_out), 0);
      chk("rst_dm", 32'({dm_req, dm_we, dm_addr, dm_wdata}), 0);
      chk("rst_flags", 32'({end_process, illegal}), 0);

      // Basic program; spurious acks outside MEM must be ignored
      ack_force = 1'b1;
      rom[0] = ins(I_LDI, 5); rom[1] = ins(I_MVR, 1); rom[2] = ins(I_LDI, 7);
      rom[3] = ins(I_ADD, 1); rom[4] = ins(I_END, 0);
      run_prog(100, cyc);
      chk("basic_ac", 32'(ac_out), 12);
      chk("basic_cycles", 32'(cyc), 14);
      chk("basic_flags", 32'({end_process, illegal}), 32'b10);
      chk("basic_pc", 32'(pc_out), 5);
      ack_force = 1'b0;

      // Single-op table: LDI r; MVR 1; LDI a; OP 1; JZ 0x100; END  (z shows up in final PC)
      for (int i = 0; i < 11; i++) begin
         clear_rom();
         rom[0] = ins(I_LDI, int'(vecs[i].r));
         rom[1] = ins(I_MVR, 1);
         rom[2] = ins(I_LDI, int'(vecs[i].a));
         rom[3] = ins(vecs[i].op, 12'hFF5);
         rom[4] = ins(I_JZ, 12'h100);
         rom[5] = ins(I_END, 0);
         run_prog(100, cyc);
         chk($sformatf("vec%0d_ac", i), 32'(ac_out), 32'(vecs[i].exp_ac));
         chk($sformatf("vec%0d_zpc", i), 32'(pc_out), vecs[i].exp_z ? 32'h101 : 32'h6);
      end

      // Wrap to zero then JZ
      clear_rom();
      rom[0] = ins(I_LDI, 12'hFFF); rom[1] = ins(I_MVR, 0); rom[2] = ins(I_INC, 0);
      rom[3] = ins(I_JZ, 12'h020);
      run_prog(100, cyc);
      chk("jz_ac", 32'(ac_out), 0);
      chk("jz_pc", 32'(pc_out), 32'h021);
      chk("jz_cycles", 32'(cyc), 14);

      // STM with three MEM cycles
      clear_rom();
      ack_lat = 3;
      dmem[12'h010] = '0;
      rom[0] = ins(I_LDI, 12'hABC); rom[1] = ins(I_STM, 12'h010);
      run_prog(100, cyc);
      chk("stm_req_cycles", 32'(req_cnt), 3);
      chk("stm_we", 32'(first_we), 1);
      chk("stm_addr", 32'(first_addr), 32'h010);
      chk("stm_wdata", 32'(first_wdata), 32'hABC);
      chk("stm_stable", 32'(req_unstable), 0);
      chk("stm_mem", 32'(dmem[12'h010]), 32'hABC);
      chk("stm_cycles", 32'(cyc), 10);

      // LDM of zero, ack in first MEM cycle
      clear_rom();
      ack_lat = 1;
      dmem[12'h030] = '0;
      rom[0] = ins(I_LDI, 7); rom[1] = ins(I_LDM, 12'h030); rom[2] = ins(I_JZ, 12'h040);
      run_prog(100, cyc);
      chk("ldm_ac", 32'(ac_out), 0);
      chk("ldm_zpc", 32'(pc_out), 32'h041);
      chk("ldm_cycles", 32'(cyc), 11);
      chk("ldm_we", 32'(first_we), 0);
      chk("ldm_req_cycles", 32'(req_cnt), 1);

      // Illegal opcode halts, PC frozen, then one-cycle reset
      clear_rom();
      rom[0] = ins(I_LDI, 3); rom[1] = ins(20, 12'h010);
      run_prog(100, cyc);
      chk("ill_flags", 32'({end_process, illegal}), 32'b01);
      chk("ill_cycles", 32'(cyc), 5);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("ill_pc_frozen", 32'(pc_out), 2);
      chk("ill_no_req", 32'(req_cnt) + 32'(dm_req), 0);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("ill_reset_outs", 32'({im_addr, pc_out, dm_req, dm_we, end_process, illegal}), 0);
      chk("ill_reset_ac", 32'(ac_out), 0);
      rst_n = 1'b1;

      // Reset in the middle of a long MEM access
      clear_rom();
      ack_lat = 20;
      dmem[12'h050] = '0;
      rom[0] = ins(I_LDI, 1); rom[1] = ins(I_STM, 12'h050);
      do_reset();
      k = 0;
      while (!dm_req && k < 20) begin
         @(posedge clk);
         @(negedge clk);
         k++;
      end
      chk("rm_req_seen", 32'(dm_req), 1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rm_req_dropped", 32'(dm_req), 0);
      chk("rm_pc", 32'(pc_out), 0);
      ack_lat = 1;
      rst_n = 1'b1;
      wait_halt(100, cyc);
      chk("rm_restart_cycles", 32'(cyc), 8);
      chk("rm_mem", 32'(dmem[12'h050]), 1);

      // Random programs against the instruction-level model
      for (int p = 0; p < 25; p++) begin
         int op, opd;
         clear_rom();
         ack_lat   = $urandom_range(1, 4);
         ack_force = 1'($urandom_range(0, 1));
         for (int a = 0; a < 8; a++) begin
            mdm[a]  = int'($urandom_range(0, 4095));
            dmem[a] = 12'(mdm[a]);
         end
         for (int i = 0; i < PLEN; i++) begin
            op = ops[$urandom_range(0, 13)];
            if (op == I_LDM || op == I_STM)                 opd = $urandom_range(0, 7);
            else if (op == I_JMP || op == I_JZ || op == I_JNZ) opd = $urandom_range(i + 1, PLEN);
            else                                           opd = $urandom_range(0, 4095);
            rom[i] = ins(op, opd);
         end
         rom[PLEN] = ($urandom_range(0, 3) == 0) ? ins($urandom_range(14, 30), 0) : ins(I_END, 0);
         model_run(ack_lat, m_ac, m_pc, m_cyc, m_end, m_ill);
         run_prog(500, cyc);
         chk($sformatf("rnd%0d_ac", p), 32'(ac_out), 32'(m_ac));
         chk($sformatf("rnd%0d_pc", p), 32'(pc_out), 32'(m_pc));
         chk($sformatf("rnd%0d_cycles", p), 32'(cyc), 32'(m_cyc));
         chk($sformatf("rnd%0d_flags", p), 32'({end_process, illegal}), 32'({m_end[0], m_ill[0]}));
         for (int a = 0; a < 8; a++)
            chk($sformatf("rnd%0d_mem%0d", p, a), 32'(dmem[a]), 32'(mdm[a]));
      end
      ack_force = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
